// File: rtl/command_stream_fetcher.sv
// Fetches a block of command words from main memory into a local command cache with
// several reads in flight. Define COMMAND_FETCH_CHECKSUM_EN to add the anOutChecksum port.
module command_stream_fetcher #(
  parameter int  ADDR_WIDTH      = 64,
  parameter int  DATA_WIDTH      = 64,
  parameter int  BUFFER_SIZE     = 64,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int CW              = $clog2(BUFFER_SIZE)
) (
  input  logic                  aClock,
  input  logic                  aReset,
  input  logic [ADDR_WIDTH-1:0] aCommandPointer,
  input  logic [CW:0]           aCommandCount,
  input  logic                  anExecute,
  input  logic                  anAbort,
  output logic [ADDR_WIDTH-1:0] anOutMemoryAddr,
  output logic                  anOutMemoryRequest,
  input  logic                  aMemoryReady,
  input  logic [DATA_WIDTH-1:0] aMemoryData,
  input  logic                  aMemoryValid,
  input  logic [CW-1:0]         aCommandIndex,
  input  logic                  aCommandRead,
  output logic [DATA_WIDTH-1:0] anOutCommandData,
  output logic                  anOutBusy,
  output logic                  anOutReady,
  output logic                  anOutError,
  output logic [CW:0]           anOutFetchedCount
`ifdef COMMAND_FETCH_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] anOutChecksum
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

  localparam logic [CW:0] BufferSizeW = BUFFER_SIZE[CW:0];
  localparam logic [CW:0] CountOne    = 1;
  localparam logic [3:0]  MaxOutW     = MAX_OUTSTANDING[3:0];

  state_t                state, stateNext;
  logic [ADDR_WIDTH-1:0] pointer;
  logic [CW:0]           count, issued, received;
  logic [3:0]            outstanding, outstandingNext;
  logic [DATA_WIDTH-1:0] cache [BUFFER_SIZE];

  logic execAccept, execReject, execEmpty, execFetch;
  logic transfer, responseIn, cacheWrite;

  assign execAccept = anExecute && (state == IDLE || state == READY);
  assign execReject = execAccept && (aCommandCount > BufferSizeW);
  assign execEmpty  = execAccept && (aCommandCount == '0);
  assign execFetch  = execAccept && !execReject && !execEmpty;

  // Abort drops the request combinationally so nothing new is accepted in the abort cycle.
  assign anOutMemoryRequest = (state == FETCH) && !anAbort && (issued < count)
                              && (outstanding < MaxOutW);
  assign transfer        = anOutMemoryRequest && aMemoryReady;
  assign responseIn      = aMemoryValid && (state == FETCH || state == DRAIN);
  assign cacheWrite      = responseIn && (state == FETCH) && !anAbort;
  assign outstandingNext = outstanding + {3'b000, transfer} - {3'b000, responseIn};

  assign anOutMemoryAddr   = pointer + {{(ADDR_WIDTH-CW-1){1'b0}}, issued};
  assign anOutBusy         = (state == FETCH) || (state == DRAIN);
  assign anOutReady        = (state == READY);
  assign anOutFetchedCount = received;

  // NOTE: stateNext gets its default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE, READY: begin
        if (execReject)     stateNext = IDLE;
        else if (execEmpty) stateNext = READY;
        else if (execFetch) stateNext = FETCH;
      end
      FETCH: begin
        if (anAbort)
          stateNext = (outstandingNext == '0) ? IDLE : DRAIN;
        else if (cacheWrite && ((received + CountOne) == count))
          stateNext = READY;
      end
      DRAIN: if (outstandingNext == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aClock) begin
    if (aReset) begin
      state       <= IDLE;
      pointer     <= '0;
      count       <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
      anOutError  <= 1'b0;
    end else begin
      state       <= stateNext;
      outstanding <= outstandingNext;
      if (transfer)   issued   <= issued + CountOne;
      if (cacheWrite) received <= received + CountOne;
      if (execReject) anOutError <= 1'b1;
      if (execEmpty) begin
        anOutError <= 1'b0;
        received   <= '0;
      end
      if (execFetch) begin
        pointer     <= aCommandPointer;
        count       <= aCommandCount;
        issued      <= '0;
        received    <= '0;
        outstanding <= '0;
        anOutError  <= 1'b0;
      end
    end
  end

  // NOTE: the cache array is deliberately not reset; it maps to RAM and unwritten words are stale by design.
  always_ff @(posedge aClock) begin
    if (cacheWrite) cache[received[CW-1:0]] <= aMemoryData;
  end

  // Registered read port; a same-cycle write to the read index returns the old word.
  always_ff @(posedge aClock) begin
    if (aReset)            anOutCommandData <= '0;
    else if (aCommandRead) anOutCommandData <= cache[aCommandIndex];
  end

`ifdef COMMAND_FETCH_CHECKSUM_EN
  always_ff @(posedge aClock) begin
    if (aReset || execAccept) anOutChecksum <= '0;
    else if (cacheWrite)      anOutChecksum <= anOutChecksum ^ aMemoryData;
  end
`endif

endmodule

// File: tb/tb_command_stream_fetcher.sv
// Randomised self-checking bench for command_stream_fetcher: a queue-based memory responder
// and a transaction-level model of the fetch rules predict every output each cycle.
module tb_command_stream_fetcher;

  localparam int ADDR_WIDTH      = 64;
  localparam int DATA_WIDTH      = 64;
  localparam int BUFFER_SIZE     = 64;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CW              = $clog2(BUFFER_SIZE);

  logic                  aClock, aReset;
  logic [ADDR_WIDTH-1:0] aCommandPointer;
  logic [CW:0]           aCommandCount;
  logic                  anExecute, anAbort;
  logic [ADDR_WIDTH-1:0] anOutMemoryAddr;
  logic                  anOutMemoryRequest, aMemoryReady, aMemoryValid;
  logic [DATA_WIDTH-1:0] aMemoryData, anOutCommandData;
  logic [CW-1:0]         aCommandIndex;
  logic                  aCommandRead;
  logic                  anOutBusy, anOutReady, anOutError;
  logic [CW:0]           anOutFetchedCount;
`ifdef COMMAND_FETCH_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] anOutChecksum;
`endif

  command_stream_fetcher #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .BUFFER_SIZE(BUFFER_SIZE), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .aClock(aClock), .aReset(aReset),
    .aCommandPointer(aCommandPointer), .aCommandCount(aCommandCount),
    .anExecute(anExecute), .anAbort(anAbort),
    .anOutMemoryAddr(anOutMemoryAddr), .anOutMemoryRequest(anOutMemoryRequest),
    .aMemoryReady(aMemoryReady), .aMemoryData(aMemoryData), .aMemoryValid(aMemoryValid),
    .aCommandIndex(aCommandIndex), .aCommandRead(aCommandRead),
    .anOutCommandData(anOutCommandData),
    .anOutBusy(anOutBusy), .anOutReady(anOutReady), .anOutError(anOutError),
    .anOutFetchedCount(anOutFetchedCount)
`ifdef COMMAND_FETCH_CHECKSUM_EN
    , .anOutChecksum(anOutChecksum)
`endif
  );

  initial begin
    aClock = 1'b0;
    forever #5 aClock = ~aClock;
  end

  typedef enum {PH_IDLE, PH_FETCH, PH_DRAIN, PH_READY} phase_t;
  typedef struct { longint due; logic [63:0] data; bit stale; } resp_t;

  int total = 0;
  int bad   = 0;

  // Memory responder configuration and in-flight read queue
  resp_t       respQ[$];
  longint      edgeNo = 0, lastDue = 0;
  int          readyMode = 0, readyPct = 100, latMin = 1, latMax = 1;
  logic [63:0] salt = '0;
  bit          useTable = 0;
  logic [63:0] tablePtr = '0;
  logic [63:0] wordTable [3];

  // Reference model of the fetcher
  phase_t      ph = PH_IDLE;
  logic [63:0] mPtr = '0, mRead = '0, mSum = '0;
  int          mCnt = 0, mIssued = 0, mRecv = 0;
  bit          mErr = 0, mReadKnown = 0, modelLive = 0;
  logic [63:0] mCache [BUFFER_SIZE];
  bit          mKnown [BUFFER_SIZE];
  logic [63:0] seenAddr[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] memWord(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - tablePtr;
    if (useTable && off < 3) return wordTable[off[1:0]];
    return addr ^ salt;
  endfunction

  function automatic int inflightCount();
    int n = 0;
    foreach (respQ[i]) if (!respQ[i].stale) n++;
    return n;
  endfunction

  // One clock cycle: respond to memory traffic, predict the edge, then check outputs.
  task automatic tick();
    int          inflight, after;
    bit          vNow, vStale, xfer;
    logic [63:0] vData;
    longint      due;
    #1;
    inflight = inflightCount();
    vNow = 0; vStale = 0; vData = '0;
    if (respQ.size() > 0 && respQ[0].due <= edgeNo) begin
      vNow = 1; vStale = respQ[0].stale; vData = respQ[0].data;
      void'(respQ.pop_front());
    end
    aMemoryValid = vNow;
    aMemoryData  = vNow ? vData : {$urandom, $urandom};
    case (readyMode)
      0:       aMemoryReady = 1'b1;
      1:       aMemoryReady = ~aMemoryReady;
      default: aMemoryReady = ($urandom_range(99) < readyPct);
    endcase
    if (modelLive)
      check("request", anOutMemoryRequest,
            ph == PH_FETCH && !anAbort && mIssued < mCnt && inflight < MAX_OUTSTANDING);
    xfer = modelLive && anOutMemoryRequest && aMemoryReady;
    if (xfer) begin
      check("addr", anOutMemoryAddr, mPtr + 64'(mIssued));
      due = edgeNo + longint'($urandom_range(latMax, latMin));
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      respQ.push_back('{due: due, data: memWord(anOutMemoryAddr), stale: aReset});
      if (!aReset) seenAddr.push_back(anOutMemoryAddr);
    end
    after = inflight + int'(xfer && !aReset) - int'(vNow && !vStale);

    if (aReset) begin
      mRead = '0; mReadKnown = 1;
    end else if (aCommandRead) begin
      mRead = mCache[aCommandIndex]; mReadKnown = mKnown[aCommandIndex];
    end
    if (aReset) begin
      ph = PH_IDLE; mRecv = 0; mErr = 0; mSum = '0; mIssued = 0; mCnt = 0; mPtr = '0;
      foreach (respQ[i]) respQ[i].stale = 1;
    end else begin
      case (ph)
        PH_IDLE, PH_READY: if (anExecute) begin
          mSum = '0;
          if (aCommandCount > BUFFER_SIZE) begin
            mErr = 1; ph = PH_IDLE;
          end else if (aCommandCount == 0) begin
            mErr = 0; mRecv = 0; ph = PH_READY;
          end else begin
            mPtr = aCommandPointer; mCnt = int'(aCommandCount);
            mIssued = 0; mRecv = 0; mErr = 0; ph = PH_FETCH;
            seenAddr.delete();
          end
        end
        PH_FETCH: if (anAbort) begin
          ph = (after == 0) ? PH_IDLE : PH_DRAIN;
        end else begin
          if (xfer) mIssued++;
          if (vNow && !vStale) begin
            mCache[mRecv] = vData; mKnown[mRecv] = 1; mSum ^= vData; mRecv++;
            if (mRecv == mCnt) ph = PH_READY;
          end
        end
        PH_DRAIN: if (after == 0) ph = PH_IDLE;
        default: ;
      endcase
    end

    @(posedge aClock);
    edgeNo++;
    @(negedge aClock);
    check("busy", anOutBusy, ph == PH_FETCH || ph == PH_DRAIN);
    check("ready", anOutReady, ph == PH_READY);
    check("error", anOutError, mErr);
    check("fetched", anOutFetchedCount, 64'(mRecv));
    if (mReadKnown) check("cmdData", anOutCommandData, mRead);
`ifdef COMMAND_FETCH_CHECKSUM_EN
    check("checksum", anOutChecksum, mSum);
`endif
  endtask

  task automatic startFetch(input logic [63:0] p, input int c);
    aCommandPointer = p;
    aCommandCount   = c[CW:0];
    anExecute       = 1'b1;
    tick();
    anExecute       = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while ((ph == PH_FETCH || ph == PH_DRAIN || anOutBusy) && n < budget) begin
      tick();
      n++;
    end
    check("doneInBudget", anOutBusy, 1'b0);
  endtask

  task automatic readCache(input int idx);
    aCommandIndex = idx[CW-1:0];
    aCommandRead  = 1'b1;
    tick();
    aCommandRead  = 1'b0;
  endtask

  initial begin
    int          n;
    logic [63:0] t2Ptr, t2Salt, t4Ptr, t4Salt;
    logic [63:0] wrapExp [4];
    wrapExp = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1};
    foreach (mKnown[i]) mKnown[i] = 0;
    aReset = 1'b1; aCommandPointer = '0; aCommandCount = '0; anExecute = 1'b0;
    anAbort = 1'b0; aMemoryReady = 1'b0; aMemoryData = '0; aMemoryValid = 1'b0;
    aCommandIndex = '0; aCommandRead = 1'b0;

    // Reset state
    @(negedge aClock);
    tick();
    modelLive = 1;
    tick();
    aReset = 1'b0;
    check("rstRequest", anOutMemoryRequest, 0);
    check("rstBusy", anOutBusy, 0);
    check("rstReady", anOutReady, 0);
    check("rstError", anOutError, 0);
    check("rstFetched", anOutFetchedCount, 0);
    check("rstCmdData", anOutCommandData, 0);
    check("rstAddr", anOutMemoryAddr, 0);

    // Full 64-word fetch, 1-cycle latency, data equals address
    readyMode = 0; latMin = 1; latMax = 1; salt = '0;
    startFetch(64'h1000, 64);
    n = 1;
    while (!anOutReady && n < 200) begin tick(); n++; end
    check("t1ReadyCycle", n, 66);
    check("t1Fetched", anOutFetchedCount, 64);
    readCache(5);
    check("t1Index5", anOutCommandData, 64'h1005);

    // Toggling ready with long latency
    readyMode = 1; latMin = 6; latMax = 6;
    t2Salt = {$urandom, $urandom}; salt = t2Salt;
    t2Ptr = {$urandom, $urandom};
    startFetch(t2Ptr, 8);
    waitDone(300);
    check("t2Transfers", seenAddr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      readCache(i);
      check("t2Word", anOutCommandData, (t2Ptr + 64'(i)) ^ t2Salt);
    end

    // Oversized count is rejected, then a zero count completes at once
    readyMode = 0; latMin = 1; latMax = 1;
    startFetch({$urandom, $urandom}, 65);
    check("t3Error", anOutError, 1);
    check("t3Idle", anOutBusy | anOutReady, 0);
    check("t3NoRequest", anOutMemoryRequest, 0);
    startFetch({$urandom, $urandom}, 0);
    check("t3ZeroReady", anOutReady, 1);
    check("t3ZeroError", anOutError, 0);
    check("t3ZeroFetched", anOutFetchedCount, 0);

    // Abort after five responses with three reads still in flight
    latMin = 3; latMax = 3;
    t4Salt = {$urandom, $urandom}; salt = t4Salt;
    t4Ptr = {$urandom, $urandom};
    startFetch(t4Ptr, 16);
    n = 0;
    while (anOutFetchedCount != 5 && n < 100) begin tick(); n++; end
    check("t4Reach5", anOutFetchedCount, 5);
    check("t4Outstanding", inflightCount(), 3);
    anAbort = 1'b1;
    tick();
    anAbort = 1'b0;
    check("t4Draining", anOutBusy, 1);
    n = 0;
    while (anOutBusy && n < 50) begin tick(); n++; end
    check("t4Idle", anOutBusy | anOutReady, 0);
    check("t4Drained", respQ.size(), 0);
    check("t4Fetched", anOutFetchedCount, 5);
    readCache(5);
    check("t4Index5Kept", anOutCommandData, (t2Ptr + 64'd5) ^ t2Salt);
    readCache(4);
    check("t4Index4", anOutCommandData, (t4Ptr + 64'd4) ^ t4Salt);

    // Address wrap, with an execute pulse mid-fetch that must be ignored
    readyMode = 2; readyPct = 60; latMin = 1; latMax = 5; salt = {$urandom, $urandom};
    startFetch(64'hFFFF_FFFF_FFFF_FFFE, 4);
    tick();
    aCommandPointer = 64'h5000; aCommandCount = 10; anExecute = 1'b1;
    tick();
    anExecute = 1'b0;
    waitDone(300);
    check("t5Transfers", seenAddr.size(), 4);
    for (int i = 0; i < 4; i++) check("t5Addr", seenAddr[i], wrapExp[i]);
    for (int i = 0; i < 4; i++) readCache(i);

    // Reset in the middle of a fetch; late responses must be ignored
    readyMode = 0; latMin = 4; latMax = 4;
    startFetch({$urandom, $urandom}, 32);
    for (int i = 0; i < 10; i++) tick();
    aReset = 1'b1;
    tick();
    aReset = 1'b0;
    check("t6Request", anOutMemoryRequest, 0);
    check("t6Addr", anOutMemoryAddr, 0);
    check("t6CmdData", anOutCommandData, 0);
    n = 0;
    while (respQ.size() > 0 && n < 50) begin tick(); n++; end
    check("t6StaleDrained", respQ.size(), 0);
    tick();

    // Random fetches with random ready, latency and occasional aborts
    for (int it = 0; it < 8; it++) begin
      int c;
      bit allowAbort;
      readyMode = 2; readyPct = int'($urandom_range(100, 25));
      latMin = 1; latMax = int'($urandom_range(10, 1));
      salt = {$urandom, $urandom};
      allowAbort = ($urandom_range(2) == 0);
      c = ($urandom_range(9) == 0) ? 65 : int'($urandom_range(64, 0));
      startFetch({$urandom, $urandom}, c);
      n = 0;
      while ((ph == PH_FETCH || ph == PH_DRAIN) && n < 3000) begin
        anAbort = (ph == PH_FETCH) && allowAbort && ($urandom_range(39) == 0);
        tick();
        n++;
      end
      anAbort = 1'b0;
      check("rndDone", anOutBusy, 0);
      for (int r = 0; r < 6; r++) readCache(int'($urandom_range(BUFFER_SIZE - 1)));
    end

`ifdef COMMAND_FETCH_CHECKSUM_EN
    // Checksum accumulation and clear on the next execute
    readyMode = 0; latMin = 2; latMax = 2;
    useTable = 1; tablePtr = 64'h200;
    wordTable = '{64'h1, 64'h2, 64'h4};
    startFetch(64'h200, 3);
    waitDone(100);
    check("ckReady", anOutReady, 1);
    check("ckSum", anOutChecksum, 64'h7);
    wordTable = '{64'h8, 64'h10, 64'h20};
    startFetch(64'h200, 3);
    check("ckCleared", anOutChecksum, 64'h0);
    waitDone(100);
    check("ckSum2", anOutChecksum, 64'h38);
    useTable = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
